// File: rtl/mips16_pkg.sv
// Shared constants and the fetch-sequencer state encoding for the mips16 front end.
package mips16_pkg;

  localparam int PC_W  = 10;
  localparam int IMM_W = 7;

  localparam logic [PC_W-1:0] RESET_PC = 10'h000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/ack port between the fetch sequencer (master) and imem (slave).
interface pc_fetch_sequencer_if #(
  parameter int PC_W = mips16_pkg::PC_W
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);

endinterface

// File: rtl/branch_target_calc.sv
// Combinational branch target: base + sign-extended immediate, wrapping modulo 2^PC_W.
module branch_target_calc #(
  parameter int PC_W  = mips16_pkg::PC_W,
  parameter int IMM_W = mips16_pkg::IMM_W
) (
  input  logic [PC_W-1:0]  base,
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  target
);

  import mips16_pkg::*;

  // Carry out of the top bit is dropped, so overflow and underflow simply wrap.
  assign target = base + {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer feeding IF/ID.
// Optional redirect counter enabled by defining PC_FETCH_REDIRECT_COUNT_EN.
module pc_fetch_sequencer #(
  parameter int              PC_W     = mips16_pkg::PC_W,
  parameter int              IMM_W    = mips16_pkg::IMM_W,
  parameter logic [PC_W-1:0] RESET_PC = mips16_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_pc,
  input  logic [IMM_W-1:0]    branch_imm,
  input  logic                jump,
  input  logic [PC_W-1:0]     jump_target,
  pc_fetch_sequencer_if.master imem,
  output logic                if_valid,
  output logic [PC_W-1:0]     if_pc,
  output logic                flush
`ifdef PC_FETCH_REDIRECT_COUNT_EN
  ,
  output logic [15:0]         redirect_count
`endif
);

  import mips16_pkg::*;

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] pend_target, pend_target_n;
  logic            pend_valid, pend_valid_n;
  logic            if_valid_n, flush_n;
  logic [PC_W-1:0] if_pc_n;
  logic [PC_W-1:0] branch_target, target;
  logic            redirect;

  branch_target_calc #(.PC_W(PC_W), .IMM_W(IMM_W)) u_branch_target_calc (
    .base   (branch_pc),
    .imm    (branch_imm),
    .target (branch_target)
  );

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;

  assign imem.imem_req  = (state == ISSUE) || (state == WAIT);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      flush       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      if_valid    <= if_valid_n;
      if_pc       <= if_pc_n;
      flush       <= flush_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    if_valid_n    = 1'b0;
    if_pc_n       = if_pc;
    flush_n       = 1'b0;

    case (state)
      BOOT: begin
        // Any ack seen here belongs to a request killed by reset and is ignored.
        state_n = ISSUE;
        if (redirect) begin
          pc_n    = target;
          flush_n = 1'b1;
        end
      end

      ISSUE, WAIT: begin
        if (redirect) begin
          flush_n = 1'b1;
          // An un-acked WAIT request must complete first, so park the target.
          if (state == ISSUE || imem.imem_ack) begin
            pc_n         = target;
            pend_valid_n = 1'b0;
            state_n      = ISSUE;
          end else begin
            pend_valid_n  = 1'b1;
            pend_target_n = target;
            state_n       = WAIT;
          end
        end else if (imem.imem_ack) begin
          if (pend_valid) begin
            pc_n         = pend_target;
            pend_valid_n = 1'b0;
            state_n      = ISSUE;
          end else if (stall) begin
            state_n = HOLD;
          end else begin
            if_valid_n = 1'b1;
            if_pc_n    = pc;
            pc_n       = pc + {{(PC_W-1){1'b0}}, 1'b1};
            state_n    = ISSUE;
          end
        end else begin
          state_n = WAIT;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_n    = target;
          flush_n = 1'b1;
          state_n = ISSUE;
        end else if (!stall) begin
          if_valid_n = 1'b1;
          if_pc_n    = pc;
          pc_n       = pc + {{(PC_W-1){1'b0}}, 1'b1};
          state_n    = ISSUE;
        end
      end

      default: state_n = BOOT;
    endcase
  end

`ifdef PC_FETCH_REDIRECT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count <= '0;
    end else if (redirect && (redirect_count != 16'hFFFF)) begin
      redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed redirects, wrap cases, WAIT redirect, reset mid-request.
module tb_pc_fetch_sequencer;

  import mips16_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_pc;
  logic [IMM_W-1:0] branch_imm;
  logic             jump;
  logic [PC_W-1:0]  jump_target;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             flush;
  logic             zero_wait;
  logic             man_ack;
`ifdef PC_FETCH_REDIRECT_COUNT_EN
  logic [15:0]      redirect_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int flush_seen  = 0;

  logic [PC_W-1:0] exp_fetch[$];
  logic [PC_W-1:0] exp_ifpc[$];

  pc_fetch_sequencer_if imem_bus ();

  // Memory model: either acks in the same cycle as the request or follows man_ack.
  assign imem_bus.imem_ack = zero_wait ? imem_bus.imem_req : man_ack;

  pc_fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem         (imem_bus.master),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .flush        (flush)
`ifdef PC_FETCH_REDIRECT_COUNT_EN
    ,
    .redirect_count (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic j, input logic [PC_W-1:0] jt,
                               input logic b, input logic [PC_W-1:0] bpc,
                               input logic [IMM_W-1:0] bimm);
    jump         = j;
    jump_target  = jt;
    branch_taken = b;
    branch_pc    = bpc;
    branch_imm   = bimm;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_imem_req",  32'(imem_bus.imem_req),  32'(1'b0));
    checkOutput("rst_imem_addr", 32'(imem_bus.imem_addr), 32'(10'h000));
    checkOutput("rst_if_valid",  32'(if_valid),           32'(1'b0));
    checkOutput("rst_if_pc",     32'(if_pc),              32'(10'h000));
    checkOutput("rst_flush",     32'(flush),              32'(1'b0));
  endtask

  // Monitor: pops the expected fetch address on every accepted request and the
  // expected IF/ID PC on every if_valid, independently of the stimulus thread.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_bus.imem_req && imem_bus.imem_ack) begin
        if (exp_fetch.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL fetch_extra: got 0x%0h, expected no fetch", imem_bus.imem_addr);
        end else begin
          checkOutput("fetch_addr", 32'(imem_bus.imem_addr), 32'(exp_fetch.pop_front()));
        end
      end
      if (if_valid) begin
        if (exp_ifpc.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL if_extra: got if_pc 0x%0h, expected no if_valid", if_pc);
        end else begin
          checkOutput("if_pc", 32'(if_pc), 32'(exp_ifpc.pop_front()));
        end
      end
      if (if_valid || flush)
        checkOutput("valid_flush_excl", 32'(if_valid & flush), 32'(1'b0));
      if (flush)
        flush_seen++;
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; zero_wait = 1'b1; man_ack = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    step(2);
    checkReset();

    // Zero-wait sequential fetch from RESET_PC.
    exp_fetch.push_back(10'h000); exp_fetch.push_back(10'h001);
    exp_fetch.push_back(10'h002); exp_fetch.push_back(10'h003);
    exp_ifpc.push_back(10'h000);  exp_ifpc.push_back(10'h001);
    exp_ifpc.push_back(10'h002);
    rst = 1'b0;
    step(4);

    // Forward overflow: 0x3FE + 5 -> 0x003.
    exp_fetch.push_back(10'h003); exp_fetch.push_back(10'h004);
    exp_ifpc.push_back(10'h003);
    applyStimulus(1'b0, '0, 1'b1, 10'h3FE, 7'h05);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("fwd_flush",    32'(flush),              32'(1'b1));
    checkOutput("fwd_if_valid", 32'(if_valid),           32'(1'b0));
    checkOutput("fwd_addr",     32'(imem_bus.imem_addr), 32'(10'h003));
    step(1);
    checkOutput("fwd_flush_single", 32'(flush),    32'(1'b0));
    checkOutput("fwd_if_valid_on",  32'(if_valid), 32'(1'b1));

    // Backward underflow: 0x002 - 4 -> 0x3FE, then sequential wrap 0x3FF -> 0x000.
    exp_fetch.push_back(10'h3FE); exp_fetch.push_back(10'h3FF);
    exp_fetch.push_back(10'h000);
    exp_ifpc.push_back(10'h3FE);  exp_ifpc.push_back(10'h3FF);
    applyStimulus(1'b0, '0, 1'b1, 10'h002, 7'h7C);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("bwd_addr",  32'(imem_bus.imem_addr), 32'(10'h3FE));
    checkOutput("bwd_flush", 32'(flush),              32'(1'b1));
    step(2);

    // Jump and branch together: jump wins.
    applyStimulus(1'b1, 10'h100, 1'b1, 10'h010, 7'h01);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("jmp_pri_addr",  32'(imem_bus.imem_addr), 32'(10'h100));
    checkOutput("jmp_pri_flush", 32'(flush),              32'(1'b1));

    // Slow memory: request 0x020, redirect to 0x200 while it is outstanding.
    zero_wait = 1'b0; man_ack = 1'b0;
    exp_fetch.push_back(10'h020);
    applyStimulus(1'b1, 10'h020, 1'b0, '0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("wait_issue_addr", 32'(imem_bus.imem_addr), 32'(10'h020));
    step(1);
    checkOutput("wait_c1_addr", 32'(imem_bus.imem_addr), 32'(10'h020));
    checkOutput("wait_c1_req",  32'(imem_bus.imem_req),  32'(1'b1));
    applyStimulus(1'b1, 10'h200, 1'b0, '0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("wait_redir_addr",  32'(imem_bus.imem_addr), 32'(10'h020));
    checkOutput("wait_redir_req",   32'(imem_bus.imem_req),  32'(1'b1));
    checkOutput("wait_redir_flush", 32'(flush),              32'(1'b1));
    step(1);
    checkOutput("wait_c3_addr",  32'(imem_bus.imem_addr), 32'(10'h020));
    checkOutput("wait_c3_flush", 32'(flush),              32'(1'b0));
    exp_fetch.push_back(10'h200);
    exp_ifpc.push_back(10'h200);
    man_ack = 1'b1;
    step(1);
    man_ack = 1'b0; zero_wait = 1'b1;
    checkOutput("pend_addr",     32'(imem_bus.imem_addr), 32'(10'h200));
    checkOutput("pend_req",      32'(imem_bus.imem_req),  32'(1'b1));
    checkOutput("pend_if_valid", 32'(if_valid),           32'(1'b0));
    step(1);

    // Reset mid-WAIT with stall high and a late ack arriving.
    zero_wait = 1'b0; stall = 1'b1;
    step(1);
    checkOutput("midwait_addr", 32'(imem_bus.imem_addr), 32'(10'h201));
    checkOutput("midwait_req",  32'(imem_bus.imem_req),  32'(1'b1));
    rst = 1'b1; man_ack = 1'b1;
    step(1);
    checkReset();
    exp_fetch.push_back(10'h000); exp_fetch.push_back(10'h001);
    exp_ifpc.push_back(10'h000);  exp_ifpc.push_back(10'h001);
    rst = 1'b0;
    step(1);
    checkOutput("boot_if_valid", 32'(if_valid),           32'(1'b0));
    checkOutput("boot_addr",     32'(imem_bus.imem_addr), 32'(10'h000));
    checkOutput("boot_req",      32'(imem_bus.imem_req),  32'(1'b1));
    zero_wait = 1'b1; stall = 1'b0; man_ack = 1'b0;
    step(2);
    zero_wait = 1'b0;
    step(2);

    checkOutput("fetch_queue_left", 32'(exp_fetch.size()), 32'(0));
    checkOutput("ifpc_queue_left",  32'(exp_ifpc.size()),  32'(0));
    checkOutput("flush_cycles",     32'(flush_seen),       32'(5));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and issues fetch requests to instruction memory.
- Consumes the branch-target arithmetic: a taken branch resolves as pc + signed immediate, with the same wrap rules as the branch adder.
- Sits between the decode/execute branch resolution logic and the instruction-memory port.
- Delivers one fetched-PC token per instruction to the IF/ID stage.

Parameters:
PC_W, 10, program counter / instruction address width
IMM_W, 7, signed branch immediate width
RESET_PC, 10'h000, first fetch address after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hazard stall from decode; hold current fetch token
branch_taken  input  1  resolved taken branch, single-cycle pulse
branch_pc  input  PC_W  base PC of the branch (pc of the instruction after the branch)
branch_imm  input  IMM_W  two's-complement branch offset
jump  input  1  absolute jump, single-cycle pulse
jump_target  input  PC_W  absolute jump address
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_W  fetch address; stable while imem_req high
imem_ack  input  1  memory has returned data for imem_addr
if_valid  output  1  fetched instruction valid for IF/ID this cycle
if_pc  output  PC_W  PC of the instruction presented with if_valid
flush  output  1  one-cycle pulse: younger instructions in IF/ID must be squashed

Behaviour:
- Reset (rst=1 on an edge):
  - outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, flush=0.
  - internal: state=BOOT, pending redirect cleared.
  - Reset wins over every other input, including mid-request; any outstanding ack is ignored for one cycle after reset.
- States:
  - BOOT: one cycle, then ISSUE.
  - ISSUE: imem_req=1 with imem_addr=pc. Go to WAIT next cycle, or stay if imem_ack already high in the same cycle (zero-wait memory).
  - WAIT: imem_req held, imem_addr held until imem_ack.
  - HOLD: ack received while stall=1; instruction parked, if_valid deasserted, until stall=0.
- Ack handling:
  - imem_ack with stall=0 and no redirect: if_valid=1 and if_pc=imem_addr next cycle; pc <= pc+1 modulo 2^PC_W, so 10'h3FF wraps to 10'h000; back to ISSUE.
  - Steady-state throughput with a zero-wait memory is one instruction per cycle.
- Redirect target:
  - jump: target = jump_target.
  - branch_taken: target = branch_pc + sign_extend(branch_imm) modulo 2^PC_W. Unsigned overflow and underflow wrap silently; there is no exception.
- Priority: rst > jump > branch_taken > stall > sequential increment. Jump and branch_taken in the same cycle: jump taken, branch ignored.
- Redirect while idle (ISSUE with no request outstanding, or HOLD):
  - pc <= target, flush=1 next cycle, parked instruction dropped, then ISSUE at target.
- Redirect while a request is outstanding (WAIT):
  - Never abort an in-flight request: imem_req/imem_addr held until ack.
  - Target stored in a pending register; flush=1 next cycle.
  - Returned data discarded, if_valid stays 0.
  - Next ISSUE uses the pending target. A second redirect before the ack overwrites the pending target (latest wins).
- if_valid and flush are never both 1 in the same cycle.
- stall does not freeze an outstanding request; it only blocks handoff to IF/ID.

Optional Feature:
- Macro: PC_FETCH_REDIRECT_COUNT_EN.
- When defined:
  - Adds output redirect_count [15:0]: counts accepted redirects (jump or branch_taken), saturating at 16'hFFFF.
  - Cleared by rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (mips16_pkg) holds:
  - PC_W and IMM_W constants;
  - the state encoding typedef (BOOT, ISSUE, WAIT, HOLD);
  - RESET_PC default.
- One sub-module is natural: branch_target_calc, the combinational pc + sign-extended immediate with wrap. It is instantiated once and is reusable by the branch-address path.

Test Plan:
- Reset release, zero-wait memory (imem_ack tied to imem_req) -> imem_addr 0x000, 0x001, 0x002 on consecutive cycles; if_pc follows one cycle later.
- Forward overflow: branch_pc=0x3FE, branch_imm=+5 (7'h05) -> next fetch at 0x003, flush pulse for exactly one cycle.
- Backward underflow: branch_pc=0x002, branch_imm=-4 (7'h7C) -> next fetch at 0x3FE.
- Jump and branch in the same cycle: jump_target=0x100 with branch_pc=0x010, branch_imm=+1 -> fetch 0x100.
- Redirect during WAIT: memory acks 3 cycles after req to 0x020; jump to 0x200 in cycle 1 -> imem_addr stays 0x020 until ack, no if_valid for 0x020, then req 0x200.
- rst asserted mid-WAIT with stall=1 -> all outputs at reset values next cycle, a late ack is ignored, and the first fetch after BOOT is at RESET_PC.
